data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 192 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// data_mem_responder: RV32I data-memory slave, fixed-LATENCY ack; optional MISALIGN_TRAP_EN
// Revision: 1.0  initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wr_data_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rd_data_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      lane_q, lane_d;
  logic [2:0]      f3_q, f3_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [31:0]     rd_data_q, rd_data_d;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            cur_we;
  logic [AW-1:0]   cur_idx;
  logic [1:0]      cur_lane;
  logic [2:0]      cur_f3;
  logic [31:0]     cur_wdata;
  logic [31:0]     cur_word;
  logic [1:0]      eff_lane;
  logic            illegal;
  logic            misalign;
  logic            cur_err;
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [31:0]     load_val;
  logic [31:0]     store_word;
  logic            enter_resp;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^addr_i[31:AW+2];

  // In IDLE the access being decoded is the one on the inputs (LATENCY=1 enters
  // RESP on the accept edge); afterwards it is the captured copy.
  always_comb begin
    cur_we    = (state_q == IDLE) ? we_i              : we_q;
    cur_idx   = (state_q == IDLE) ? addr_i[AW+1:2]    : idx_q;
    cur_lane  = (state_q == IDLE) ? addr_i[1:0]       : lane_q;
    cur_f3    = (state_q == IDLE) ? funct3_i          : f3_q;
    cur_wdata = (state_q == IDLE) ? wr_data_i         : wdata_q;
    cur_word  = mem_q[cur_idx];

    if (cur_we) illegal = !(cur_f3 == 3'b000 || cur_f3 == 3'b001 || cur_f3 == 3'b010);
    else        illegal = (cur_f3 == 3'b011 || cur_f3 == 3'b110 || cur_f3 == 3'b111);

`ifdef MISALIGN_TRAP_EN
    misalign = ((cur_f3[1:0] == 2'b01) && cur_lane[0]) ||
               ((cur_f3[1:0] == 2'b10) && (cur_lane != 2'b00));
    eff_lane = cur_lane;
`else
    misalign = 1'b0;
    if (cur_f3[1:0] == 2'b01)      eff_lane = {cur_lane[1], 1'b0};
    else if (cur_f3[1:0] == 2'b10) eff_lane = 2'b00;
    else                           eff_lane = cur_lane;
`endif
    cur_err = illegal | misalign;

    sel_byte = cur_word[{eff_lane, 3'b000} +: 8];
    sel_half = cur_word[{eff_lane[1], 4'b0000} +: 16];
    case (cur_f3)
      3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b010:  load_val = cur_word;
      3'b100:  load_val = {24'd0, sel_byte};
      3'b101:  load_val = {16'd0, sel_half};
      default: load_val = 32'd0;
    endcase

    store_word = cur_word;
    case (cur_f3)
      3'b000:  store_word[{eff_lane, 3'b000} +: 8]     = cur_wdata[7:0];
      3'b001:  store_word[{eff_lane[1], 4'b0000} +: 16] = cur_wdata[15:0];
      3'b010:  store_word = cur_wdata;
      default: store_word = cur_word;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    idx_d      = idx_q;
    lane_d     = lane_q;
    f3_d       = f3_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rd_data_d  = rd_data_q;
    enter_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          idx_d   = addr_i[AW+1:2];
          lane_d  = addr_i[1:0];
          f3_d    = funct3_i;
          wdata_d = wr_data_i;
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      err_d = cur_err;
      if (cur_err)      rd_data_d = 32'd0;
      else if (!cur_we) rd_data_d = load_val;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      lane_q    <= 2'b00;
      f3_q      <= 3'b000;
      wdata_q   <= 32'd0;
      err_q     <= 1'b0;
      rd_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      idx_q     <= idx_d;
      lane_q    <= lane_d;
      f3_q      <= f3_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is never cleared; a reset on the RESP edge suppresses the commit.
  always_ff @(posedge clock_i) begin
    if (!reset_i && (state_q == RESP) && we_q && !err_q) begin
      mem_q[idx_q] <= store_word;
    end
  end

  assign ready_o   = (state_q == IDLE);
  assign ack_o     = (state_q == RESP);
  assign err_o     = (state_q == RESP) && err_q;
  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// tb_data_mem_responder: vector table + scoreboard bench for data_mem_responder
// (LATENCY=2 and LATENCY=1 instances).
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, req0, req1, we;
  logic [31:0] addr, wd;
  logic [2:0]  f3;
  logic        rdy0, ack0, err0, rdy1, ack1, err1;
  logic [31:0] rd0, rd1;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clock_i(clk), .reset_i(rst0), .req_i(req0), .we_i(we), .addr_i(addr),
    .funct3_i(f3), .wr_data_i(wd), .ready_o(rdy0), .ack_o(ack0),
    .rd_data_o(rd0), .err_o(err0));

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clock_i(clk), .reset_i(rst1), .req_i(req1), .we_i(we), .addr_i(addr),
    .funct3_i(f3), .wr_data_i(wd), .ready_o(rdy1), .ack_o(ack1),
    .rd_data_o(rd1), .err_o(err1));

  logic        use1 = 1'b0;
  logic        rdy_s, ack_s, err_s;
  logic [31:0] rd_s;
  assign rdy_s = use1 ? rdy1 : rdy0;
  assign ack_s = use1 ? ack1 : ack0;
  assign err_s = use1 ? err1 : err0;
  assign rd_s  = use1 ? rd1  : rd0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];
  vec_t sb [$];
  int   nerr = 0;
  int   nchk = 0;

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [2:0] f,
                              input logic [31:0] d, input logic [31:0] r, input logic e);
    vec_t v;
    v.we = w; v.addr = a; v.f3 = f; v.wd = d; v.rd = r; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the selected DUT idle; returns at the negedge after RESP.
  task automatic access(input vec_t v, input string tag);
    int   lat;
    int   c;
    vec_t e;
    lat = use1 ? 1 : 2;
    check({tag, " ready"}, 32'(rdy_s), 32'd1);
    we = v.we; addr = v.addr; f3 = v.f3; wd = v.wd;
    if (use1) req1 = 1'b1; else req0 = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    c = 0;
    for (int i = 1; i <= 20 && c == 0; i++) begin
      @(negedge clk);
      if (ack_s) c = i;
    end
    check({tag, " ack latency"}, 32'(c), 32'(lat));
    e = sb.pop_front();
    check({tag, " rd_data"}, rd_s, e.rd);
    check({tag, " err"}, 32'(err_s), 32'(e.err));
    @(negedge clk);
    check({tag, " ack single"}, 32'(ack_s), 32'd0);
    check({tag, " err idle"}, 32'(err_s), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, consec, rdybad, databad, ackpulse;
    logic prev;

    tbl[0]  = mk(1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0);
    tbl[1]  = mk(0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0);
    tbl[2]  = mk(1, 32'h20, 3'b010, 32'h80000001, 32'hDEADBEEF, 0);
    tbl[3]  = mk(0, 32'h20, 3'b000, 32'h0, 32'h00000001, 0);
    tbl[4]  = mk(0, 32'h23, 3'b000, 32'h0, 32'hFFFFFF80, 0);
    tbl[5]  = mk(0, 32'h23, 3'b100, 32'h0, 32'h00000080, 0);
    tbl[6]  = mk(0, 32'h22, 3'b101, 32'h0, 32'h00008000, 0);
    tbl[7]  = mk(1, 32'h20, 3'b010, 32'h11223344, 32'h00008000, 0);
    tbl[8]  = mk(1, 32'h21, 3'b000, 32'hFFFFFFAA, 32'h00008000, 0);
    tbl[9]  = mk(0, 32'h20, 3'b010, 32'h0, 32'h1122AA44, 0);
    tbl[10] = mk(0, 32'h22, 3'b001, 32'h0, 32'h00001122, 0);
    tbl[11] = mk(1, 32'h22, 3'b001, 32'h0000BEEF, 32'h00001122, 0);
    tbl[12] = mk(0, 32'h22, 3'b001, 32'h0, 32'hFFFFBEEF, 0);
    tbl[13] = mk(0, 32'h20, 3'b010, 32'h0, 32'hBEEFAA44, 0);
    tbl[14] = mk(0, 32'h410, 3'b010, 32'h0, 32'hDEADBEEF, 0);
    tbl[15] = mk(0, 32'h80000010, 3'b010, 32'h0, 32'hDEADBEEF, 0);
    tbl[16] = mk(0, 32'h10, 3'b011, 32'h0, 32'h0, 1);
    tbl[17] = mk(0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0);
    tbl[18] = mk(1, 32'h10, 3'b100, 32'h12345678, 32'h0, 1);
    tbl[19] = mk(0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0);
    tbl[20] = mk(1, 32'h40, 3'b010, 32'hCAFEF00D, 32'hDEADBEEF, 0);
    tbl[22] = mk(1, 32'h40, 3'b111, 32'h0, 32'h0, 1);
`ifdef MISALIGN_TRAP_EN
    tbl[21] = mk(0, 32'h42, 3'b010, 32'h0, 32'h0, 1);
    tbl[23] = mk(0, 32'h43, 3'b001, 32'h0, 32'h0, 1);
    tbl[24] = mk(1, 32'h43, 3'b010, 32'h01020304, 32'h0, 1);
    tbl[25] = mk(0, 32'h40, 3'b010, 32'h0, 32'hCAFEF00D, 0);
    tbl[26] = mk(0, 32'h41, 3'b100, 32'h0, 32'h000000F0, 0);
    tbl[27] = mk(1, 32'h30, 3'b010, 32'h00000077, 32'h000000F0, 0);
`else
    tbl[21] = mk(0, 32'h42, 3'b010, 32'h0, 32'hCAFEF00D, 0);
    tbl[23] = mk(0, 32'h43, 3'b001, 32'h0, 32'hFFFFCAFE, 0);
    tbl[24] = mk(1, 32'h43, 3'b010, 32'h01020304, 32'hFFFFCAFE, 0);
    tbl[25] = mk(0, 32'h40, 3'b010, 32'h0, 32'h01020304, 0);
    tbl[26] = mk(0, 32'h41, 3'b100, 32'h0, 32'h00000003, 0);
    tbl[27] = mk(1, 32'h30, 3'b010, 32'h00000077, 32'h00000003, 0);
`endif

    rst0 = 1'b1; rst1 = 1'b1; req0 = 1'b0; req1 = 1'b0;
    we = 1'b0; addr = 32'h0; f3 = 3'b010; wd = 32'h0;
    repeat (3) @(negedge clk);
    check("reset ready", 32'(rdy0), 32'd1);
    check("reset ack", 32'(ack0), 32'd0);
    check("reset err", 32'(err0), 32'd0);
    check("reset rd_data", rd0, 32'd0);
    check("reset1 ready", 32'(rdy1), 32'd1);
    check("reset1 ack", 32'(ack1), 32'd0);
    rst0 = 1'b0; rst1 = 1'b0;

    for (int i = 0; i < NV; i++) access(tbl[i], $sformatf("vec%0d", i));

    // Reset in WAIT, with req_i also high during the reset cycle.
    we = 1'b1; addr = 32'h30; f3 = 3'b010; wd = 32'h5; req0 = 1'b1;
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b1; req0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0; req0 = 1'b0;
    ackpulse = 0;
    @(negedge clk);
    check("wait-reset ready", 32'(rdy0), 32'd1);
    check("wait-reset rd_data", rd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (ack0) ackpulse++;
      if (i < 4) @(negedge clk);
    end
    check("wait-reset no ack", 32'(ackpulse), 32'd0);

    // Reset on the RESP cycle: ack seen, but the store must not commit.
    we = 1'b1; addr = 32'h30; f3 = 3'b010; wd = 32'h9; req0 = 1'b1;
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("resp-reset ack", 32'(ack0), 32'd1);
    rst0 = 1'b1;
    @(posedge clk); #1 rst0 = 1'b0;
    @(negedge clk);
    check("resp-reset ack gone", 32'(ack0), 32'd0);
    access(mk(0, 32'h30, 3'b010, 32'h0, 32'h00000077, 0), "after-reset LW");

    // LATENCY=1 instance.
    use1 = 1'b1;
    access(mk(1, 32'h10, 3'b010, 32'hA5A55A5A, 32'h0, 0), "L1 SW");
    access(mk(0, 32'h12, 3'b001, 32'h0, 32'hFFFFA5A5, 0), "L1 LH");
    access(mk(0, 32'h10, 3'b100, 32'h0, 32'h0000005A, 0), "L1 LBU");
    access(mk(0, 32'h10, 3'b010, 32'h0, 32'hA5A55A5A, 0), "L1 LW");

    we = 1'b0; addr = 32'h10; f3 = 3'b010; req1 = 1'b1;
    acks = 0; consec = 0; rdybad = 0; databad = 0; prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack1) acks++;
      if (ack1 && prev) consec++;
      if (rdy1 == ack1) rdybad++;
      if (ack1 && (rd1 !== 32'hA5A55A5A || err1 !== 1'b0)) databad++;
      prev = ack1;
    end
    req1 = 1'b0;
    check("L1 stream acks", 32'(acks), 32'd10);
    check("L1 stream back-to-back ack", 32'(consec), 32'd0);
    check("L1 stream ready", 32'(rdybad), 32'd0);
    check("L1 stream data", 32'(databad), 32'd0);
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard leftover: got %0d expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
